// File: rtl/alu_wb_stage.sv
// Execute/writeback stage for the 16x16 register file: eight ALU ops, a 16-cycle
// shift-add multiplier, and a one-deep bypass from the value currently being written.
module alu_wb_stage #(
  parameter int WIDTH        = 16,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [2:0]       op,
  input  logic [3:0]       rs,
  input  logic [3:0]       rt,
  input  logic [3:0]       rd,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [3:0]       Caddr,
  output logic             Load,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] c_reg;
  logic [3:0]       caddr_reg;
  logic             load_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [3:0]       cnt_reg;
  logic [3:0]       rd_reg;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] acc_next;
  logic             rd_wr_ok;
  logic             rd_reg_wr_ok;

  assign ready_in = (state_reg == ST_IDLE);
  assign busy     = (state_reg == ST_MUL);
  assign C        = c_reg;
  assign Caddr    = caddr_reg;
  assign Load     = load_reg;

  // Forward the value on the write port; Load is never high for a suppressed r0 write.
  assign op_a = (load_reg && caddr_reg == rs) ? c_reg : A;
  assign op_b = (load_reg && caddr_reg == rt) ? c_reg : B;

  assign rd_wr_ok     = !(R0_HARDWIRED && rd == 4'd0);
  assign rd_reg_wr_ok = !(R0_HARDWIRED && rd_reg == 4'd0);

  // Logarithmic left shifter: stage gi shifts by 2**gi when op_b[gi] is set.
  logic [WIDTH-1:0] sll_stage [0:4];
  assign sll_stage[0] = op_a;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sll
      assign sll_stage[gi+1] = op_b[gi] ? (sll_stage[gi] << (1 << gi)) : sll_stage[gi];
    end
  endgenerate

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
      OP_SLL:  alu_result = sll_stage[4];
      default: alu_result = '0;
    endcase
  end

  assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_reg  <= ST_IDLE;
      c_reg      <= '0;
      caddr_reg  <= '0;
      load_reg   <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      rd_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_in) begin
            if (op == OP_MUL) begin
              mcand_reg  <= op_a;
              mplier_reg <= op_b;
              acc_reg    <= '0;
              cnt_reg    <= '0;
              rd_reg     <= rd;
              state_reg  <= ST_MUL;
              load_reg   <= 1'b0;
            end else begin
              c_reg     <= alu_result;
              caddr_reg <= rd;
              load_reg  <= rd_wr_ok;
            end
          end else begin
            load_reg <= 1'b0;
          end
        end
        default: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 4'd1;
          load_reg   <= 1'b0;
          // Sixteenth iteration: write the finished product back.
          if (cnt_reg == 4'd15) begin
            c_reg     <= acc_next;
            caddr_reg <= rd_reg;
            load_reg  <= rd_reg_wr_ok;
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
